// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: synchronises and debounces two push keys, turns presses into
// single-cycle events and sequences a 4-mode LED pattern off an internal tick.
module sw_led_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned TICK_CNT     = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key0,
  input  logic       i_key1,
  output logic [3:0] o_led,
  output logic [1:0] o_mode,
  output logic       o_paused
);

  localparam int unsigned DB_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int unsigned TK_W = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_CNT - 1);

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SHIFT  = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  // Bit 0 = key0, bit 1 = key1 throughout.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      key_db;
  logic [1:0]      key_db_prev;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  logic [1:0]      mode;
  logic            paused;
  logic [TK_W-1:0] tick_cnt;
  logic [3:0]      pattern;

  logic [1:0]      next_mode;
  logic [3:0]      entry_pattern;
  logic [3:0]      tick_pattern;
  logic            running;

  // Two-stage synchroniser for both raw keys.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {i_key1, i_key0};
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CNT consecutive differing edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_db <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == key_db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          key_db[k] <= ~key_db[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // One registered pulse per debounced rising edge; release is ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_db_prev <= 2'b00;
      press       <= 2'b00;
    end else begin
      key_db_prev <= key_db;
      press       <= key_db & ~key_db_prev;
    end
  end

  // Entry pattern of the next mode and the per-tick update of the current one.
  always_comb begin
    next_mode = mode + 2'd1;
    running   = (mode != MODE_DIRECT) && !paused;

    case (next_mode)
      MODE_BLINK: entry_pattern = 4'b1111;
      MODE_SHIFT: entry_pattern = 4'b0001;
      default:    entry_pattern = 4'b0000;
    endcase

    case (mode)
      MODE_BLINK: tick_pattern = ~pattern;
      MODE_SHIFT: tick_pattern = {pattern[2:0], pattern[3]};
      MODE_COUNT: tick_pattern = pattern + 4'd1;
      default:    tick_pattern = pattern;
    endcase
  end

  // Mode/pause control and tick-driven pattern; key0 wins over key1 on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode     <= MODE_DIRECT;
      paused   <= 1'b0;
      tick_cnt <= '0;
      pattern  <= 4'b0000;
    end else if (press[0]) begin
      mode     <= next_mode;
      paused   <= 1'b0;
      tick_cnt <= '0;
      pattern  <= entry_pattern;
    end else begin
      if (press[1] && (mode != MODE_DIRECT)) begin
        paused <= ~paused;
      end
      if (running) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          pattern  <= tick_pattern;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  // DIRECT shows key logic from the debounced levels; other modes show the pattern.
  always_comb begin
    if (mode == MODE_DIRECT) begin
      o_led = {key_db[0] | key_db[1], key_db[0] & key_db[1], key_db[1], key_db[0]};
    end else begin
      o_led = pattern;
    end
  end

  assign o_mode   = mode;
  assign o_paused = paused;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Bench for sw_led_ctrl with D=4, TICK_CNT=4: directed scenarios plus random key
// activity, all checked against a behavioural model of the key/mode rules.
module tb_sw_led_ctrl;

  localparam int D = 4;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key0 = 1'b0;
  logic       key1 = 1'b0;
  logic [3:0] o_led;
  logic [1:0] o_mode;
  logic       o_paused;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sw_led_ctrl #(
    .DEBOUNCE_CNT(D),
    .TICK_CNT    (T)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key0  (key0),
    .i_key1  (key1),
    .o_led   (o_led),
    .o_mode  (o_mode),
    .o_paused(o_paused)
  );

  // Behavioural model: raw sample history, debounced levels, delayed press actions,
  // and the number of running clocks since the current mode was entered.
  logic       h0 [0:D];
  logic       h1 [0:D];
  logic       m_db0 = 1'b0, m_db1 = 1'b0;
  logic [1:0] p0 = 2'b00, p1 = 2'b00;
  logic [1:0] m_mode = 2'd0;
  logic       m_paused = 1'b0;
  int         m_el = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= D; i++) begin
        h0[i] = 1'b0;
        h1[i] = 1'b0;
      end
      m_db0 = 1'b0; m_db1 = 1'b0; p0 = 2'b00; p1 = 2'b00;
      m_mode = 2'd0; m_paused = 1'b0; m_el = 0;
    end else begin
      logic a0, a1, f0, f1;
      a0 = p0[1];
      a1 = p1[1];
      // A level is accepted once the last D synchronised samples all disagree.
      f0 = 1'b1;
      f1 = 1'b1;
      for (int i = 1; i <= D; i++) begin
        if (h0[i] == m_db0) f0 = 1'b0;
        if (h1[i] == m_db1) f1 = 1'b0;
      end
      p0 = {p0[0], f0 & ~m_db0};
      p1 = {p1[0], f1 & ~m_db1};
      if (f0) m_db0 = ~m_db0;
      if (f1) m_db1 = ~m_db1;
      for (int i = D; i > 0; i--) begin
        h0[i] = h0[i-1];
        h1[i] = h1[i-1];
      end
      h0[0] = key0;
      h1[0] = key1;
      if (m_mode != 2'd0 && !m_paused) m_el++;
      if (a0) begin
        m_mode = m_mode + 2'd1;
        m_el = 0;
        m_paused = 1'b0;
      end else if (a1 && m_mode != 2'd0) begin
        m_paused = ~m_paused;
      end
    end
  end

  // Expected LEDs derived from the number of ticks since mode entry.
  function automatic logic [3:0] exp_led();
    int n;
    n = m_el / T;
    case (m_mode)
      2'd0:    return {m_db0 | m_db1, m_db0 & m_db1, m_db1, m_db0};
      2'd1:    return (n % 2 == 0) ? 4'b1111 : 4'b0000;
      2'd2:    return 4'(1 << (n % 4));
      default: return 4'(n % 16);
    endcase
  endfunction

  // Stimulus only: hold the given keys, release, then let the debouncer settle.
  task automatic press(input logic k0, input logic k1);
    @(negedge clk);
    key0 = k0;
    key1 = k1;
    repeat (D + 4) @(negedge clk);
    key0 = 1'b0;
    key1 = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({o_mode, o_paused, o_led} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got mode=%0d paused=%0b led=%b want 0/0/0000",
               o_mode, o_paused, o_led);
    end
    rst = 1'b0;
  endtask

  task automatic test_mode_step();
    int edge_n;
    edge_n = 0;
    @(negedge clk);
    key0 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (o_mode == 2'd1) begin
        edge_n = e;
        break;
      end
    end
    total++;
    if (edge_n != 8 || o_led !== 4'b1111) begin
      bad++;
      $display("FAIL step_latency: got edge=%0d led=%b want edge=8 led=1111", edge_n, o_led);
    end
    repeat (42) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL step_hold: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
    key0 = 1'b0;
    repeat (D + 4) @(negedge clk);
    total++;
    if (o_mode !== 2'd1) begin
      bad++;
      $display("FAIL step_once: got mode=%0d want 1", o_mode);
    end
  endtask

  task automatic test_blink_shift();
    repeat (12) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL blink: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
    press(1'b1, 1'b0);
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL shift: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
  endtask

  task automatic test_count_pause();
    logic [3:0] held;
    press(1'b1, 1'b0);
    repeat (64) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL count: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
    press(1'b0, 1'b1);
    held = o_led;
    repeat (40) begin
      @(negedge clk);
      total++;
      if (o_paused !== 1'b1 || o_led !== held || o_led !== exp_led()) begin
        bad++;
        $display("FAIL pause_freeze: got paused=%0b led=%b want paused=1 led=%b",
                 o_paused, o_led, held);
      end
    end
    press(1'b0, 1'b1);
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL resume: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] start_mode;
    logic       bounce [5];
    start_mode = o_mode;
    @(negedge clk);
    key0 = 1'b1;
    repeat (3) @(negedge clk);
    key0 = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (o_mode !== start_mode) begin
      bad++;
      $display("FAIL short_glitch: got mode=%0d want %0d", o_mode, start_mode);
    end
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      key0 = bounce[i];
      @(negedge clk);
    end
    key0 = 1'b1;
    repeat (30) @(negedge clk);
    key0 = 1'b0;
    repeat (D + 4) @(negedge clk);
    total++;
    if (o_mode !== start_mode + 2'd1 || o_mode !== m_mode) begin
      bad++;
      $display("FAIL bounce_once: got mode=%0d want %0d", o_mode, start_mode + 2'd1);
    end
  endtask

  task automatic test_direct();
    // Expects DIRECT on entry.
    @(negedge clk);
    key0 = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (o_led !== 4'b1001 || o_mode !== 2'd0) begin
      bad++;
      $display("FAIL direct_key0: got mode=%0d led=%b want 0/1001", o_mode, o_led);
    end
    repeat (2) @(negedge clk);
    total++;
    if (o_mode !== 2'd1) begin
      bad++;
      $display("FAIL direct_step: got mode=%0d want 1", o_mode);
    end
    key0 = 1'b0;
    repeat (D + 4) @(negedge clk);
    repeat (3) press(1'b1, 1'b0);
    @(negedge clk);
    key1 = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (o_led !== 4'b1010 || o_mode !== 2'd0 || o_paused !== 1'b0) begin
      bad++;
      $display("FAIL direct_key1: got mode=%0d paused=%0b led=%b want 0/0/1010",
               o_mode, o_paused, o_led);
    end
    repeat (6) @(negedge clk);
    key1 = 1'b0;
    repeat (D + 4) @(negedge clk);
    total++;
    if (o_paused !== 1'b0 || o_mode !== 2'd0) begin
      bad++;
      $display("FAIL direct_nopause: got mode=%0d paused=%0b want 0/0", o_mode, o_paused);
    end
    repeat (2) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    total++;
    if (o_mode !== 2'd3 || o_paused !== 1'b0 || o_mode !== m_mode) begin
      bad++;
      $display("FAIL both_keys: got mode=%0d paused=%0b want 3/0", o_mode, o_paused);
    end
  endtask

  task automatic test_async_reset();
    int found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_led === 4'b0101) begin
        found = 1;
        break;
      end
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL reach_0101: got led=%b want 0101 within 200 cycles", o_led);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({o_mode, o_paused, o_led} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: got %0d/%0b/%b want 0/0/0000", o_mode, o_paused, o_led);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== 7'b0) begin
        bad++;
        $display("FAIL post_reset_idle: got %0d/%0b/%b want 0/0/0000",
                 o_mode, o_paused, o_led);
      end
    end
    press(1'b1, 1'b0);
    repeat (12) begin
      @(negedge clk);
      total++;
      if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
        bad++;
        $display("FAIL post_reset_run: got %0d/%0b/%b want %0d/%0b/%b",
                 o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
      end
    end
  endtask

  task automatic test_random();
    int unsigned hold;
    for (int n = 0; n < 80; n++) begin
      key0 = 1'($urandom_range(0, 1));
      key1 = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 14);
      repeat (hold) begin
        @(negedge clk);
        total++;
        if ({o_mode, o_paused, o_led} !== {m_mode, m_paused, exp_led()}) begin
          bad++;
          $display("FAIL random: got %0d/%0b/%b want %0d/%0b/%b",
                   o_mode, o_paused, o_led, m_mode, m_paused, exp_led());
        end
      end
    end
    key0 = 1'b0;
    key1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_step();
    test_blink_shift();
    test_count_pause();
    test_glitch();
    test_direct();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop in case a scenario stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sw_led_ctrl.md
Name: sw_led_ctrl

Overview:
Key-driven LED mode controller for the board's two push keys and four LEDs. It synchronises and debounces both keys and turns key presses into single-cycle events. A 4-state mode FSM sequences the LED pattern: direct key/logic display, blink, running light and binary count, each timed by an internal tick. It sits between the raw key pins and the LED pins and supersedes direct combinational key-to-LED wiring.

Parameters:
DEBOUNCE_CNT, 500000, consecutive clocks a synchronised key level must differ from the debounced level before it is accepted (10 ms at 50 MHz); minimum 2.
TICK_CNT, 25000000, clocks per pattern tick (0.5 s at 50 MHz); minimum 2.

Ports:
i_clk  input  1  system clock; all state on rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_key0  input  1  raw key 0, asynchronous, 1 = pressed; press advances mode.
i_key1  input  1  raw key 1, asynchronous, 1 = pressed; press toggles pause.
o_led  output  4  LED drive, 1 = lit.
o_mode  output  2  current mode: 0 DIRECT, 1 BLINK, 2 SHIFT, 3 COUNT.
o_paused  output  1  1 = tick generation frozen.

Behaviour:
- Reset (async assert, released synchronously by the user's reset logic): sync FFs, debounced levels, debounce counters, press pulses, tick counter, pattern = 0; mode = DIRECT; paused = 0; o_led = 4'b0000; o_mode = 0.
- Sync: 2 FF stages per key. A level first sampled at edge E1 is the synchronised level after E2.
- Debounce, per key: counter increments each edge while the synchronised level differs from the debounced level; it clears whenever they are equal. On the DEBOUNCE_CNT-th consecutive differing edge the debounced level flips and the counter clears. A glitch shorter than DEBOUNCE_CNT clocks is never accepted.
- Press pulse: registered 1-cycle pulse on the debounced 0->1 transition. One pulse per press regardless of hold time; release generates nothing.
- Latency: key first sampled high at E1 -> debounced high at E(2+D) -> pulse at E(3+D) -> mode/pause update at E(4+D), where D = DEBOUNCE_CNT.
- Key0 press: mode <= mode+1, wrapping 3->0. On the same edge: tick counter <= 0, paused <= 0, pattern <= entry value of the new mode.
- Key1 press: in BLINK/SHIFT/COUNT, paused toggles. In DIRECT it is ignored and paused stays 0.
- Both pulses on the same edge: key0 action only; the key1 pulse is discarded.
- Tick: counter runs 0..TICK_CNT-1 while not paused and mode != DIRECT. Tick fires on the edge where the counter wraps to 0, i.e. every TICK_CNT clocks after mode entry. While paused, the counter and pattern hold; resume continues from the held count.
- Modes, with entry pattern and per-tick update:
  DIRECT: no tick. o_led = {key0_db|key1_db, key0_db&key1_db, key1_db, key0_db} using debounced levels.
  BLINK: entry 4'b1111; per tick, pattern <= ~pattern.
  SHIFT: entry 4'b0001; per tick, rotate left (1000 -> 0001).
  COUNT: entry 4'b0000; per tick, pattern+1 mod 16 (1111 -> 0000).
- o_led = pattern in modes 1-3; o_mode = mode; o_paused = paused. All three are driven from registers plus the debounced levels, with no combinational path from the raw keys.
- Reset mid-press or mid-tick: all state returns to the reset values immediately. A key still held when reset releases is seen as a new press once debounced.

Test Plan (D=4, TICK_CNT=4):
1. Reset, then hold key0 = 1 from edge E1 -> o_mode 0->1 exactly at E8, o_led = 1111; hold key0 for 50 clocks -> exactly one mode step.
2. In BLINK, idle 12 clocks -> o_led toggles 1111->0000->1111->0000 every 4 clocks. Press key0 -> SHIFT, o_led = 0001 then 0010, 0100, 1000, 0001 every 4 clocks.
3. Advance to COUNT, run 64 clocks -> o_led counts 0..15 and wraps to 0. Press key1 -> o_paused = 1, o_led frozen for 40 clocks. Press key1 again -> count resumes from the held value.
4. key0 pulses high for 3 clocks only (below D) -> no mode change. Bounce pattern 1,0,1,1,0 then steady 1 -> exactly one press.
5. In DIRECT, key0 held through debounce -> o_led bit0 = 1 and bit3 = 1 while debounced level is high, plus a mode step. In DIRECT, key1 alone -> o_led = 1010, o_paused stays 0. Key0 and key1 pressed on the same edge in SHIFT -> mode 3, o_paused = 0.
6. Assert i_rst mid-COUNT with o_led = 0101 -> all outputs go to 0 and DIRECT without waiting for a clock edge. After release, the first tick-driven change occurs only after a new key0 press.
